// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, TRAP} fetch_state_t;
    localparam logic [1:0]  CAUSE_NONE         = 2'd0;
    localparam logic [1:0]  CAUSE_MISALIGN     = 2'd1;
    localparam logic [1:0]  CAUSE_RANGE        = 2'd2;
    localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0013;
endpackage

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter: free-running fetch and stall event counters, wrapping at 2^32.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fetch,
    input  logic        i_stall,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_stall_count
);
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (i_fetch) r_fetch_count <= r_fetch_count + 32'd1;
            if (i_stall) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_fetch_count = r_fetch_count;
    assign o_stall_count = r_stall_count;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, next-PC selection and fetch qualification with sticky traps.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS    = 81,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        inst_valid,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_addr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);
    localparam logic [31:0] RANGE_BYTES = 32'(4 * MEM_WORDS);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [1:0]   r_cause;
    logic [31:0]  r_taddr;
    logic         w_in_range;
    logic         w_run;
    logic [31:0]  w_pc_plus4;

    // Offsetting by the reset vector makes wrapped or below-base PCs fail one unsigned compare.
    assign w_in_range = (r_pc - RESET_VECTOR) < RANGE_BYTES;
    assign w_run      = r_state == RUN;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
            r_cause <= CAUSE_NONE;
            r_taddr <= '0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (!w_in_range) begin
                        r_state <= TRAP;
                        r_cause <= CAUSE_RANGE;
                        r_taddr <= r_pc;
                    end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
                        r_state <= TRAP;
                        r_cause <= CAUSE_MISALIGN;
                        r_taddr <= redirect_target;
                    end else if (redirect_valid) begin
                        r_pc <= redirect_target;
                    end else if (!stall) begin
                        r_pc <= w_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign inst_valid = w_run && !stall && w_in_range;
    assign instr      = inst_valid ? imem_data : NOP_INSTR;
    assign trap       = r_state == TRAP;
    assign trap_cause = r_cause;
    assign trap_addr  = r_taddr;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter u_perf (
        .clk           (clk),
        .rst           (rst),
        .i_fetch       (inst_valid),
        .i_stall       (w_run && stall && !redirect_valid),
        .o_fetch_count (fetch_count),
        .o_stall_count (stall_count)
    );
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed plan scenarios plus randomized traffic checked against a behavioural model.
module tb_fetch_pc_unit;
    localparam int unsigned WORDS = 81;
    localparam logic [31:0] LIMIT = 32'(4 * WORDS);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_addr, imem_data, pc, pc_plus4, instr, trap_addr;
    logic        inst_valid, trap;
    logic [1:0]  trap_cause;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    logic [31:0] rom [WORDS];
    int          n_vec = 0;
    int          n_err = 0;

    int          m_mode = 0;
    logic [31:0] m_pc = '0;
    logic [1:0]  m_cause = '0;
    logic [31:0] m_taddr = '0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < LIMIT) ? rom[imem_addr / 4] : 32'hBAD0_BAD0;

    fetch_pc_unit #(.RESET_VECTOR(32'h0), .MEM_WORDS(WORDS), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr           (instr),
        .inst_valid      (inst_valid),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .trap_addr       (trap_addr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check all outputs against the model, then step the model at the edge.
    task automatic cyc(input logic s, input logic rv, input logic [31:0] t, input logic r);
        logic        e_valid;
        logic [31:0] e_instr;
        @(negedge clk);
        rst = r;
        stall = s;
        redirect_valid = rv;
        redirect_target = t;
        #1;
        e_valid = (m_mode == 1) && !s && (m_pc < LIMIT);
        e_instr = e_valid ? rom[m_pc / 4] : NOP;
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("inst_valid", 32'(inst_valid), 32'(e_valid));
        chk("instr", instr, e_instr);
        chk("trap", 32'(trap), 32'(m_mode == 2));
        chk("trap_cause", 32'(trap_cause), 32'(m_cause));
        chk("trap_addr", trap_addr, m_taddr);
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_pc = '0; m_cause = '0; m_taddr = '0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_pc >= LIMIT) begin
                m_mode = 2; m_cause = 2; m_taddr = m_pc;
            end else if (rv && (t % 4) != 0) begin
                m_mode = 2; m_cause = 1; m_taddr = t;
            end else if (rv) begin
                m_pc = t;
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) rom[i] = $urandom;
        rom[0] = 32'h0000_0093;
        rom[3] = 32'h0020_2223;

        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", 32'(inst_valid), 32'd0);
        cyc(0, 0, 0, 0);
        chk("first_valid", 32'(inst_valid), 32'd1);
        chk("first_instr", instr, 32'h0000_0093);
        repeat (3) cyc(0, 0, 0, 0);
        chk("seq_pc", pc, 32'h0C);
        chk("seq_instr", instr, 32'h0020_2223);
        chk("seq_plus4", pc_plus4, 32'h10);

        repeat (77) cyc(0, 0, 0, 0);
        chk("end_pc", pc, 32'h140);
        cyc(0, 1, 32'h0, 0);
        chk("loop_pc", pc, 32'h0);
        chk("loop_valid", 32'(inst_valid), 32'd1);
        chk("loop_trap", 32'(trap), 32'd0);

        repeat (8) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("stall_pc", pc, 32'h20);
        chk("stall_valid", 32'(inst_valid), 32'd0);
        cyc(1, 1, 32'h40, 0);
        chk("stall_redir_pc", pc, 32'h40);

        cyc(0, 1, 32'h10, 0);
        cyc(0, 1, 32'h102, 0);
        chk("mis_cause", 32'(trap_cause), 32'd1);
        chk("mis_addr", trap_addr, 32'h102);
        repeat (10) cyc(1'($urandom), 1'($urandom), $urandom, 0);
        chk("mis_pc_hold", pc, 32'h10);
        cyc(0, 0, 0, 1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_trap", 32'(trap), 32'd0);
        cyc(0, 0, 0, 0);

        cyc(0, 1, 32'h140, 0);
        cyc(0, 0, 0, 0);
        chk("oor_pc", pc, 32'h144);
        chk("oor_valid", 32'(inst_valid), 32'd0);
        cyc(0, 0, 0, 0);
        chk("oor_cause", 32'(trap_cause), 32'd2);
        chk("oor_addr", trap_addr, 32'h144);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] t;
            int          sel;
            sel = int'($urandom_range(0, 7));
            t = (sel == 0) ? (32'($urandom_range(0, WORDS - 1)) * 4) | 32'($urandom_range(1, 3))
              : (sel == 1) ? LIMIT + 32'($urandom_range(0, 63)) * 4
              : 32'($urandom_range(0, WORDS - 1)) * 4;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t, $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
